// File: rtl/ti_adc_cal_ctrl.sv
// rtl/ti_adc_cal_ctrl.sv - foreground offset calibration controller for a time-interleaved ADC
//
// Purpose: on a start request, shorts the ADC input to 0 V, waits for the
// analog front end to settle, then averages 2^Nacc_log2 codes from each
// slice in turn and stores the rounded mean as that slice's offset.
//
// Optional feature: define TI_ADC_CAL_CORRECT_EN to add adcout_corr, a
// registered, saturated adcin[k] - offset[k] for every slice.
//
// Ports:
//   clk          retimed ADC clock, rising edge
//   rstb         asynchronous active-low reset
//   start        calibration request, ignored while busy
//   adcin        Nti signed codes of Nadc bits, slice k at [k*Nadc +: Nadc]
//   cal_short    input short enable to the analog front end
//   slice_sel    slice currently being calibrated
//   offset       Nti stored signed offsets, same packing as adcin
//   busy         run in progress
//   done         one-cycle pulse at the end of a run
//   adcout_corr  (TI_ADC_CAL_CORRECT_EN only) offset-corrected codes

`timescale 1ns/1ps

module ti_adc_cal_ctrl #(
  parameter int Nadc      = 8,
  parameter int Nti       = 4,
  parameter int Nacc_log2 = 4,
  parameter int Nsettle   = 8
) (
  input  logic                                   clk,
  input  logic                                   rstb,
  input  logic                                   start,
  input  logic [Nti*Nadc-1:0]                    adcin,
  output logic                                   cal_short,
  output logic [((Nti > 1) ? $clog2(Nti) : 1)-1:0] slice_sel,
  output logic [Nti*Nadc-1:0]                    offset,
  output logic                                   busy,
  output logic                                   done
`ifdef TI_ADC_CAL_CORRECT_EN
  ,
  output logic [Nti*Nadc-1:0]                    adcout_corr
`endif
);

  localparam int SEL_W   = (Nti > 1) ? $clog2(Nti) : 1;
  localparam int ACC_W   = Nadc + Nacc_log2;
  localparam int ACC_N   = 1 << Nacc_log2;
  localparam int CNT_MAX = (Nsettle > ACC_N) ? Nsettle : ACC_N;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RND_SH  = (Nacc_log2 > 0) ? (Nacc_log2 - 1) : 0;
  localparam int RND     = (Nacc_log2 > 0) ? (1 << RND_SH) : 0;

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (Nadc - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(1 << (Nadc - 1)));

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ACCUM,
    S_STORE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_next;

  logic [CNT_W-1:0]         r_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic [SEL_W-1:0]         r_slice_sel;
  logic [Nti*Nadc-1:0]      r_offset;

  logic signed [Nadc-1:0]   w_sel_code;
  logic signed [ACC_W-1:0]  w_sel_ext;
  logic signed [ACC_W:0]    w_rnd;
  logic signed [ACC_W:0]    w_shf;
  logic signed [Nadc-1:0]   w_store;
  logic                     w_settle_last;
  logic                     w_accum_last;
  logic                     w_slice_last;
  logic                     w_busy;
  logic                     w_cal_short;
  logic                     w_done;

  assign w_sel_code    = adcin[r_slice_sel*Nadc +: Nadc];
  assign w_sel_ext     = ACC_W'(w_sel_code);
  assign w_settle_last = (r_cnt == CNT_W'(Nsettle - 1));
  assign w_accum_last  = (r_cnt == CNT_W'(ACC_N - 1));
  assign w_slice_last  = (r_slice_sel == SEL_W'(Nti - 1));

  // Round half up, then arithmetic shift; one guard bit keeps the +RND
  // from wrapping. With Nacc_log2=0 both RND and the shift vanish.
  assign w_rnd = (ACC_W+1)'(r_acc) + (ACC_W+1)'(RND);
  assign w_shf = w_rnd >>> Nacc_log2;

  always_comb begin
    w_store = w_shf[Nadc-1:0];
    if (w_shf > SAT_MAX) begin
      w_store = {1'b0, {(Nadc-1){1'b1}}};
    end else if (w_shf < SAT_MIN) begin
      w_store = {1'b1, {(Nadc-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_busy      = 1'b1;
    w_cal_short = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        w_cal_short = 1'b1;
        if (w_settle_last) w_next = S_ACCUM;
      end
      S_ACCUM: begin
        w_cal_short = 1'b1;
        if (w_accum_last) w_next = S_STORE;
      end
      S_STORE: begin
        w_cal_short = 1'b1;
        w_next      = S_NEXT;
      end
      S_NEXT: begin
        w_cal_short = 1'b1;
        // Later slices reuse the already-settled short.
        w_next      = w_slice_last ? S_DONE : S_ACCUM;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_slice_sel <= '0;
      r_offset    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt       <= '0;
            r_slice_sel <= '0;
          end
        end
        S_SETTLE: begin
          if (w_settle_last) begin
            r_cnt <= '0;
            r_acc <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ACCUM: begin
          r_acc <= r_acc + w_sel_ext;
          if (w_accum_last) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STORE: begin
          r_offset[r_slice_sel*Nadc +: Nadc] <= w_store;
        end
        S_NEXT: begin
          if (!w_slice_last) begin
            r_slice_sel <= r_slice_sel + 1'b1;
            r_acc       <= '0;
            r_cnt       <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = w_busy;
  assign cal_short = w_cal_short;
  assign done      = w_done;
  assign slice_sel = r_slice_sel;
  assign offset    = r_offset;

`ifdef TI_ADC_CAL_CORRECT_EN
  for (genvar k = 0; k < Nti; k++) begin : g_corr
    logic signed [Nadc:0]   w_diff;
    logic [Nadc-1:0]        w_sat;
    logic [Nadc-1:0]        r_corr;

    assign w_diff = (Nadc+1)'($signed(adcin[k*Nadc +: Nadc]))
                  - (Nadc+1)'($signed(r_offset[k*Nadc +: Nadc]));

    // Top two bits differ only when the difference left the Nadc range.
    always_comb begin
      w_sat = w_diff[Nadc-1:0];
      if (w_diff[Nadc] != w_diff[Nadc-1]) begin
        w_sat = w_diff[Nadc] ? {1'b1, {(Nadc-1){1'b0}}} : {1'b0, {(Nadc-1){1'b1}}};
      end
    end

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        r_corr <= '0;
      end else begin
        r_corr <= w_sat;
      end
    end

    assign adcout_corr[k*Nadc +: Nadc] = r_corr;
  end
`endif

endmodule
